// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the burst read path.
//               It holds the FSM state encoding and the read-buffer sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Burst reader FSM state encoding, with an explicit 2-bit width
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The read buffer depth must be a power of two, so that the pointers wrap naturally
    localparam int RD_BUF_DEPTH = 2;

    // The counter width must be able to represent the full depth
    // (0..RD_BUF_DEPTH inclusive)
    localparam int RD_BUF_CNT_W = $clog2(RD_BUF_DEPTH + 1);

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_rd_buf.sv
`default_nettype none
// ============================================================================
// Module      : mem_rd_buf
// Description : A small synchronous FIFO that holds the words returned by the
//               memory until downstream accepts them. The head word is always
//               presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rd_buf
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WORD_SIZE-1:0]    push_data,
    input  logic                    pop,
    output logic [RD_BUF_CNT_W-1:0] count,
    output logic [WORD_SIZE-1:0]    head
);

    localparam int                      c_ptr_w = $clog2(RD_BUF_DEPTH);
    localparam logic [RD_BUF_CNT_W-1:0] c_full  = RD_BUF_CNT_W'(RD_BUF_DEPTH);

    logic [WORD_SIZE-1:0]    r_mem [RD_BUF_DEPTH];
    logic [c_ptr_w-1:0]      r_wptr;
    logic [c_ptr_w-1:0]      r_rptr;
    logic [RD_BUF_CNT_W-1:0] r_count;
    logic                    w_pop;
    logic                    w_push;

    // A pop on an empty buffer is ignored. A push into a full buffer is
    // accepted only when a pop frees a slot in the same cycle.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_full) || w_pop);

    assign count = r_count;
    assign head  = r_mem[r_rptr];

    // Storage, pointers and occupancy; push and pop can both happen in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : mem_rd_buf
`default_nettype wire

// File: rtl/mem_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_reader
// Description : Accepts a burst command (start address and length) and reads
//               consecutive words from a memory with a 1-cycle read latency.
//               The words are returned on a valid/ready stream through a
//               2-entry buffer. Reads are credit-limited, so that
//               backpressure never overflows the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 4,
    parameter int ADDR_W    = 4,
    parameter int LEN_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 done
);

    localparam int                 c_acc_w = RD_BUF_CNT_W + 1;
    localparam logic [c_acc_w-1:0] c_depth = c_acc_w'(RD_BUF_DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [LEN_W-1:0]        r_remain;
    logic                    r_inflight;
    logic [RD_BUF_CNT_W-1:0] w_count;
    logic [WORD_SIZE-1:0]    w_head;
    logic                    w_pop;
    logic [c_acc_w-1:0]      w_committed;
    logic                    w_credit;
    logic                    w_drained;
    logic                    w_cmd_hs;

    // The returned words are parked here. r_inflight marks the cycle in which
    // rd_data carries a word we asked for. Clearing that flag on reset drops
    // any stale returning data.
    mem_rd_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_rd_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (rd_data),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head)
    );

    assign out_valid = (w_count != '0);
    assign out_data  = w_head;
    assign w_pop     = out_valid && out_ready;
    assign rd_addr   = r_rd_addr;
    assign w_cmd_hs  = cmd_valid && cmd_ready;

    // w_committed is the buffer occupancy after this edge, counting the
    // word still in flight. A new read is allowed only while that number
    // stays below the depth. The burst has drained once it reaches zero.
    assign w_committed = c_acc_w'(w_count) + c_acc_w'(r_inflight) - c_acc_w'(w_pop);
    assign w_credit    = (w_committed < c_depth);
    assign w_drained   = (w_committed == '0);

    // Next-state logic and the state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        rd_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = (cmd_len != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                busy  = 1'b1;
                rd_en = w_credit;
                // The length is non-zero on entry, so r_remain >= 1 in this state
                if (w_credit && (r_remain == LEN_W'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, address/length counters and the read-in-flight flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rd_addr  <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= rd_en;
            if (w_cmd_hs) begin
                r_rd_addr <= cmd_addr;
                r_remain  <= cmd_len;
            end else if (rd_en) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_remain  <= r_remain - 1'b1;
            end
        end
    end

endmodule : mem_burst_reader
`default_nettype wire
